// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte/grant widths and TX arbiter state encoding
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int GRANT_W = 3;
  localparam int MAX_REQ = 1 << GRANT_W;
  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester byte streams plus TX FIFO write side; master = arbiter, slave = requesters/FIFO
interface uart_tx_arb_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*uart_pkg::UART_BYTE_W-1:0] req_data;
  logic fifo_full;
  logic fifo_wr_en;
  logic [uart_pkg::UART_BYTE_W-1:0] fifo_din;
  modport master (input req_valid, req_last, req_data, fifo_full, output req_ready, fifo_wr_en, fifo_din);
  modport slave (output req_valid, req_last, req_data, fifo_full, input req_ready, fifo_wr_en, fifo_din);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker (req_i, last_grant_i -> any_o, first set req after last_grant_i as pick_o)
module uart_rr_pick import uart_pkg::*; #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic               any_o,
  output logic [GRANT_W-1:0] pick_o
);
  logic [MAX_REQ-1:0] req_p;
  logic [GRANT_W-1:0] idx;
  assign req_p = MAX_REQ'(req_i);
  always_comb begin
    any_o = |req_i;
    pick_o = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GRANT_W'((int'(last_grant_i) + k) % NREQ);
      if (req_p[idx]) pick_o = idx;
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin message-locked arbiter onto the UART TX FIFO write port (clk, rst_n, arb_en, bus, busy, grant_id, timeout_err)
module uart_tx_arb import uart_pkg::*; #(
  parameter int NREQ = 2,
  parameter int LOCK_TIMEOUT = 256,
  parameter int TO_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  uart_tx_arb_if.master      bus,
  output logic               busy,
  output logic [GRANT_W-1:0] grant_id,
  output logic               timeout_err
);
  arb_state_e state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic any, locked, beat, tmo, done;
  logic [MAX_REQ-1:0] valid_p, last_p;
  logic [MAX_REQ-1:0][UART_BYTE_W-1:0] data_p;
  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i(bus.req_valid),
    .last_grant_i(last_q),
    .any_o(any),
    .pick_o(pick)
  );
  assign valid_p = MAX_REQ'(bus.req_valid);
  assign last_p = MAX_REQ'(bus.req_last);
  assign data_p = (MAX_REQ * UART_BYTE_W)'(bus.req_data);
  assign locked = state_q == LOCKED;
  assign beat = locked & valid_p[grant_q] & ~bus.fifo_full;
  // a beat in the final counted cycle wins over the timeout
  assign tmo = locked & ~beat & (cnt_q == TO_W'(LOCK_TIMEOUT - 1));
  assign done = (beat & last_p[grant_q]) | tmo;
  assign bus.req_ready = locked & ~bus.fifo_full ? NREQ'(1) << grant_q : '0;
  assign bus.fifo_wr_en = beat;
  assign bus.fifo_din = beat ? data_p[grant_q] : '0;
  assign busy = locked;
  assign grant_id = grant_q;
  assign timeout_err = tmo;
  always_comb begin
    state_d = locked ? (done ? IDLE : LOCKED) : (arb_en & any ? LOCKED : IDLE);
    grant_d = ~locked & arb_en & any ? pick : grant_q;
    last_d = done ? grant_q : last_q;
    cnt_d = locked & ~beat ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GRANT_W'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a message-level round-robin model
module tb_uart_tx_arb;
  import uart_pkg::*;
  localparam int NREQ = 3;
  localparam int TO = 8;
  typedef struct {int id; logic [7:0] d; int cyc;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_en = 1'b0;
  logic busy, timeout_err;
  logic [GRANT_W-1:0] grant_id;
  uart_tx_arb_if #(.NREQ(NREQ)) bus ();
  uart_tx_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(TO), .TO_W(9)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arb_en(arb_en),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [8:0] rq [NREQ][$];
  logic [NREQ-1:0] vmask;
  logic full_v;
  logic s_wr, s_to, s_busy;
  logic [7:0] s_din;
  logic [GRANT_W-1:0] s_gid;
  logic [NREQ-1:0] s_ready, s_valid;
  wr_t wlog[$];

  task automatic tick();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = vmask[i] && rq[i].size() > 0;
      bus.req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      bus.req_last[i] = rq[i].size() > 0 && rq[i][0][8];
    end
    bus.fifo_full = full_v;
    #2;
    s_wr = bus.fifo_wr_en;
    s_din = bus.fifo_din;
    s_ready = bus.req_ready;
    s_valid = bus.req_valid;
    s_to = timeout_err;
    s_busy = busy;
    s_gid = grant_id;
    for (int i = 0; i < NREQ; i++)
      if (s_wr && s_ready[i] && s_valid[i]) wlog.push_back('{i, s_din, cyc});
    @(posedge clk);
    for (int i = 0; i < NREQ; i++)
      if (s_valid[i] && s_ready[i]) void'(rq[i].pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    vmask = '1;
    full_v = 1'b0;
    arb_en = 1'b1;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wlog.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arb_en = 1'b1;
    bus.req_valid = '1;
    bus.req_last = '1;
    bus.req_data = '1;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    tests++;
    if ({busy, grant_id, timeout_err} !== '0) begin
      fails++;
      $display("FAIL reset_regs busy=%b gid=%0d to=%b want 0", busy, grant_id, timeout_err);
    end
    tests++;
    if ({bus.req_ready, bus.fifo_wr_en, bus.fifo_din} !== '0) begin
      fails++;
      $display("FAIL reset_outs ready=%b wr=%b din=%h want 0", bus.req_ready, bus.fifo_wr_en, bus.fifo_din);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    tick();
    tests++;
    if ({s_busy, s_wr} !== 2'b00) begin
      fails++;
      $display("FAIL single_idle busy=%b wr=%b want 0 0", s_busy, s_wr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({s_busy, s_wr, s_gid, s_din} !== {1'b1, 1'b1, 3'd0, 8'h41 + 8'(k)}) begin
        fails++;
        $display("FAIL single_byte%0d busy=%b wr=%b gid=%0d din=%h want 1 1 0 %h", k, s_busy, s_wr, s_gid, s_din, 8'h41 + 8'(k));
      end
    end
    tick();
    tests++;
    if ({s_busy, s_gid} !== {1'b0, 3'd0}) begin
      fails++;
      $display("FAIL single_end busy=%b gid=%0d want 0 0", s_busy, s_gid);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] ed [8];
    int n = 0;
    ed = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back({k[0], 8'h10 + 8'(k)});
      rq[1].push_back({k[0], 8'h20 + 8'(k)});
    end
    while (wlog.size() < 8 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (wlog.size() != 8) begin
      fails++;
      $display("FAIL alt_count got %0d writes want 8", wlog.size());
      return;
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (wlog[k].id != (k / 2) % 2 || wlog[k].d !== ed[k]) begin
        fails++;
        $display("FAIL alt_w%0d id=%0d d=%h want %0d %h", k, wlog[k].id, wlog[k].d, (k / 2) % 2, ed[k]);
      end
      if (k > 0) begin
        tests++;
        if (wlog[k].cyc - wlog[k-1].cyc != (k % 2 == 0 ? 2 : 1)) begin
          fails++;
          $display("FAIL alt_gap%0d got %0d want %0d", k, wlog[k].cyc - wlog[k-1].cyc, k % 2 == 0 ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) rq[0].push_back({k == 3, 8'h30 + 8'(k)});
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        full_v = 1'b1;
        for (int j = 0; j < 5; j++) begin
          tick();
          tests++;
          if ({s_ready, s_wr, s_to} !== '0) begin
            fails++;
            $display("FAIL stall_c%0d ready=%b wr=%b to=%b want 0", j, s_ready, s_wr, s_to);
          end
        end
        full_v = 1'b0;
      end
      tick();
      tests++;
      if ({s_wr, s_din} !== {1'b1, 8'h30 + 8'(k)}) begin
        fails++;
        $display("FAIL stall_byte%0d wr=%b din=%h want 1 %h", k, s_wr, s_din, 8'h30 + 8'(k));
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rq[1].push_back({1'b0, 8'h50});
    rq[1].push_back({1'b0, 8'h51});
    tick();
    tick();
    tests++;
    if ({s_gid, s_wr, s_din} !== {3'd1, 1'b1, 8'h50}) begin
      fails++;
      $display("FAIL to_grant gid=%0d wr=%b din=%h want 1 1 50", s_gid, s_wr, s_din);
    end
    tick();
    rq[0].push_back({1'b1, 8'h60});
    for (int k = 1; k <= TO; k++) begin
      tick();
      tests++;
      if ({s_to, s_busy, s_wr} !== {k == TO, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL to_c%0d to=%b busy=%b wr=%b want %b 1 0", k, s_to, s_busy, s_wr, k == TO);
      end
    end
    tick();
    tests++;
    if ({s_busy, s_to} !== 2'b00) begin
      fails++;
      $display("FAIL to_idle busy=%b to=%b want 0 0", s_busy, s_to);
    end
    tick();
    tests++;
    if ({s_busy, s_gid, s_wr, s_din} !== {1'b1, 3'd0, 1'b1, 8'h60}) begin
      fails++;
      $display("FAIL to_next busy=%b gid=%0d wr=%b din=%h want 1 0 1 60", s_busy, s_gid, s_wr, s_din);
    end
  endtask

  task automatic test_arb_en();
    do_reset();
    for (int k = 0; k < 3; k++) rq[0].push_back({k == 2, 8'h70 + 8'(k)});
    tick();
    tick();
    arb_en = 1'b0;
    tick();
    tick();
    tests++;
    if ({s_wr, s_din} !== {1'b1, 8'h72}) begin
      fails++;
      $display("FAIL en_complete wr=%b din=%h want 1 72", s_wr, s_din);
    end
    rq[0].push_back({1'b1, 8'h73});
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if ({s_busy, s_wr} !== 2'b00) begin
        fails++;
        $display("FAIL en_hold%0d busy=%b wr=%b want 0 0", k, s_busy, s_wr);
      end
    end
    arb_en = 1'b1;
    tick();
    tick();
    tests++;
    if ({s_busy, s_wr, s_din} !== {1'b1, 1'b1, 8'h73}) begin
      fails++;
      $display("FAIL en_regrant busy=%b wr=%b din=%h want 1 1 73", s_busy, s_wr, s_din);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) rq[1].push_back({k == 2, 8'h80 + 8'(k)});
    tick();
    tick();
    rq[0].push_back({1'b1, 8'h90});
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, grant_id, timeout_err, bus.req_ready, bus.fifo_wr_en, bus.fifo_din} !== '0) begin
      fails++;
      $display("FAIL areset busy=%b gid=%0d to=%b ready=%b wr=%b din=%h want 0", busy, grant_id, timeout_err, bus.req_ready, bus.fifo_wr_en, bus.fifo_din);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if ({s_gid, s_wr, s_din} !== {3'd0, 1'b1, 8'h90}) begin
      fails++;
      $display("FAIL areset_prio gid=%0d wr=%b din=%h want 0 1 90", s_gid, s_wr, s_din);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int mlen [NREQ][$];
      logic [7:0] bq [NREQ][$];
      int mi [NREQ];
      int off [NREQ];
      wr_t exp_q[$];
      int last = NREQ - 1;
      int n = 0;
      int frun = 0;
      bit found = 1'b1;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        int nm = $urandom_range(0, 3);
        mi[i] = 0;
        off[i] = 0;
        for (int m = 0; m < nm; m++) begin
          int len = $urandom_range(1, 4);
          mlen[i].push_back(len);
          for (int b = 0; b < len; b++) begin
            logic [7:0] d = 8'($urandom);
            bq[i].push_back(d);
            rq[i].push_back({b == len - 1, d});
          end
        end
      end
      while (found) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ && !found; k++) begin
          int j = (last + k) % NREQ;
          if (mi[j] < mlen[j].size()) begin
            for (int b = 0; b < mlen[j][mi[j]]; b++) exp_q.push_back('{j, bq[j][off[j] + b], 0});
            off[j] += mlen[j][mi[j]];
            mi[j]++;
            last = j;
            found = 1'b1;
          end
        end
      end
      while (wlog.size() < exp_q.size() && n < 3000) begin
        full_v = frun < 5 && $urandom_range(0, 9) < 3;
        frun = full_v ? frun + 1 : 0;
        tick();
        n++;
        if (full_v) begin
          tests++;
          if ({s_wr, |s_ready} !== 2'b00) begin
            fails++;
            $display("FAIL rnd%0d_full wr=%b ready=%b want 0", r, s_wr, s_ready);
          end
        end
      end
      full_v = 1'b0;
      tests++;
      if (wlog.size() != exp_q.size()) begin
        fails++;
        $display("FAIL rnd%0d_count got %0d writes want %0d", r, wlog.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
        tests++;
        if (wlog[k].id != exp_q[k].id || wlog[k].d !== exp_q[k].d) begin
          fails++;
          $display("FAIL rnd%0d_w%0d id=%0d d=%h want %0d %h", r, k, wlog[k].id, wlog[k].d, exp_q[k].id, exp_q[k].d);
        end
      end
    end
  endtask

  initial begin
    vmask = '1;
    full_v = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_timeout();
    test_arb_en();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter sharing the single UART TX byte FIFO write port among `NREQ` byte-stream requesters (core MMIO store path, debug/trace printer, boot monitor). Each requester sends whole messages under a lock: once granted, it keeps the FIFO until its `last` byte is accepted or it stalls past a timeout. The block sits between the requesters and the `uart_if` TX FIFO write side (`din`/`wr_en`/`full`). It adds no buffering of its own.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `LOCK_TIMEOUT`, 256, idle cycles while locked before the grant is forcibly released (≥2)
- `TO_W`, 9, width of the timeout counter; must hold `LOCK_TIMEOUT`
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `arb_en`  in  1  permit new grants; an in-progress message always completes
- `req_valid`  in  NREQ  per-requester byte valid
- `req_data`  in  NREQ*8  per-requester byte; requester i on bits [8i+7:8i]
- `req_last`  in  NREQ  byte is the final byte of a message
- `req_ready`  out  NREQ  byte accepted this cycle when valid&ready
- `fifo_full`  in  1  TX FIFO full
- `fifo_wr_en`  out  1  TX FIFO write strobe
- `fifo_din`  out  8  TX FIFO write data
- `busy`  out  1  a grant is held (state LOCKED)
- `grant_id`  out  3  index of the current/last granted requester
- `timeout_err`  out  1  one-cycle pulse when a lock is released by timeout

## Operation
- States: IDLE, LOCKED.
- IDLE: if `arb_en` and any `req_valid`, pick the first valid requester searching from `last_grant+1` modulo NREQ. Register `grant_id`, clear the timeout counter and enter LOCKED. No byte is accepted in IDLE.
- LOCKED: `req_ready[grant_id] = ~fifo_full`; all other ready bits are 0. Beat = `req_valid[g] & req_ready[g]`. On a beat, `fifo_wr_en`=1 and `fifo_din = req_data[g]` combinationally in the same cycle.
- Beat with `req_last` → IDLE; `last_grant <= g`.
- Timeout counter: increments every LOCKED cycle without a beat, including cycles stalled on `fifo_full`. It clears on a beat.
- When the counter reaches `LOCK_TIMEOUT-1` with no beat → IDLE, `last_grant <= g`, `timeout_err` pulses for 1 cycle. A beat in that same cycle takes priority and there is no timeout.
- `arb_en` low during LOCKED has no effect until the message ends.
- Valid bytes from non-granted requesters are held (never dropped); requesters must keep `valid`/`data` stable until accepted.
- `fifo_wr_en` is never asserted while `fifo_full`=1.

## Timing
- Reset values: state IDLE, `grant_id`=0, `last_grant`=NREQ-1 (requester 0 wins first), `busy`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_din`=0, `timeout_err`=0, counter=0.
- Grant latency: valid seen in IDLE at cycle t → LOCKED at t+1 → first byte written at t+1 at the earliest.
- Throughput inside a message: 1 byte/cycle while `~fifo_full`.
- Between messages: exactly one IDLE bubble cycle.
- Reset asserted mid-message: immediate return to reset values. A partially written message stays in the FIFO; the arbiter does not purge it.
- `busy` and `grant_id` are registered outputs. `req_ready`, `fifo_wr_en` and `fifo_din` are combinational from state, `fifo_full` and the granted requester's inputs.

## Structure
- Shared package `uart_pkg`: `UART_BYTE_W`=8, arbiter state enum (IDLE/LOCKED), `GRANT_W`=3.
- Sub-module `uart_rr_pick`: combinational round-robin picker (`req` vector + `last_grant` → `any`, `pick` index), reusable by the future RX-side scheduler.
- The top level holds the FSM, timeout counter and mux.

## Test plan
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43. Expect: grant at cycle 1; `fifo_wr_en` on 3 consecutive cycles with data 0x41..0x43; `busy` falls afterwards; `grant_id`=0.
- req0 and req1 both valid with 2-byte messages. Expect: req0 served first, one bubble, then req1. Repeat: order alternates 0,1,0,1.
- `fifo_full` held high for 5 cycles mid-message. Expect: `req_ready`=0 and no writes during the stall; resume with the correct next byte; no `timeout_err`.
- Granted req1 drops valid and never sends last, with `LOCK_TIMEOUT`=8. Expect: `timeout_err` pulse 8 cycles after the last beat, return to IDLE, req0 (pending) granted next.
- `arb_en` deasserted mid-message. Expect: the message completes, then no new grant while req0 is valid; after `arb_en` rises, grant follows within 1 cycle.
- Reset asserted during LOCKED. Expect: all outputs at reset values immediately (asynchronous); after release, requester 0 has priority.
